// File: rtl/seg7_scan_controller.sv
// Multiplexed scan controller for a common-anode multi-digit 7-segment display.
// Steps one digit per slot with dead-time blanking, leading-zero suppression and frame-aligned updates.
module seg7_scan_controller #(
    parameter int DIGITS       = 4,
    parameter int PRESCALE     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  lz_suppress,
    output logic [3:0]            nibble,
    output logic [DIGITS-1:0]     an,
    output logic                  dp_n,
    output logic [2:0]            digit_idx,
    output logic                  frame_tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST_COUNT = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYCLES);
    localparam logic [2:0]    LAST_DIGIT = 3'(DIGITS - 1);

    logic [PW-1:0]       prescaler;
    logic [4*DIGITS-1:0] display;
    logic [4*DIGITS-1:0] pending_value;
    logic [DIGITS-1:0]   dp_shadow;
    logic [DIGITS-1:0]   pending_dp;
    logic                pending_valid;

    logic [3:0]          nibble_next;
    logic [DIGITS-1:0]   an_next;
    logic                dp_next;
    logic                dp_sel;
    logic                upper_zero;
    logic                suppressed;
    logic                lit;
    logic                slot_end;

    assign slot_end   = (prescaler == LAST_COUNT);
    assign frame_tick = enable && slot_end && (digit_idx == LAST_DIGIT);

    // A digit is blanked as a leading zero only if it and every digit above it are zero.
    always_comb begin
        nibble_next = 4'd0;
        dp_sel      = 1'b0;
        upper_zero  = 1'b1;
        an_next     = '1;
        for (int k = 0; k < DIGITS; k++) begin
            if ((k >= int'(digit_idx)) && (display[4*k +: 4] != 4'd0)) begin
                upper_zero = 1'b0;
            end
            if (k == int'(digit_idx)) begin
                nibble_next = display[4*k +: 4];
                dp_sel      = dp_shadow[k];
            end
        end
        suppressed = lz_suppress && (digit_idx != 3'd0) && upper_zero;
        lit        = enable && (prescaler >= BLANK_END) && !suppressed;
        for (int k = 0; k < DIGITS; k++) begin
            if (lit && (k == int'(digit_idx))) begin
                an_next[k] = 1'b0;
            end
        end
        dp_next = !(lit && dp_sel);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an     <= '1;
            nibble <= 4'd0;
            dp_n   <= 1'b1;
        end else begin
            an     <= an_next;
            nibble <= nibble_next;
            dp_n   <= dp_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            digit_idx <= 3'd0;
        end else if (enable) begin
            if (slot_end) begin
                prescaler <= '0;
                digit_idx <= (digit_idx == LAST_DIGIT) ? 3'd0 : digit_idx + 3'd1;
            end else begin
                prescaler <= prescaler + 1'b1;
            end
        end
    end

    // New values only reach the display at a frame boundary so a frame never shows a mix.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            display       <= '0;
            dp_shadow     <= '0;
            pending_value <= '0;
            pending_dp    <= '0;
            pending_valid <= 1'b0;
        end else if (frame_tick) begin
            pending_valid <= 1'b0;
            if (load) begin
                display   <= value_in;
                dp_shadow <= dp_in;
            end else if (pending_valid) begin
                display   <= pending_value;
                dp_shadow <= pending_dp;
            end
        end else if (load) begin
            if (enable) begin
                pending_value <= value_in;
                pending_dp    <= dp_in;
                pending_valid <= 1'b1;
            end else begin
                display   <= value_in;
                dp_shadow <= dp_in;
            end
        end
    end

endmodule
